// File: rtl/craps_pkg.sv
// Shared encodings and constants for the craps referee.
package craps_pkg;

  typedef enum logic [1:0] {
    S_READY = 2'd0,
    S_POINT = 2'd1,
    S_WIN   = 2'd2,
    S_LOSE  = 2'd3
  } state_e;

  localparam logic [3:0] SUM_SEVEN   = 4'd7;
  localparam logic [3:0] SUM_ELEVEN  = 4'd11;
  localparam logic [3:0] SUM_CRAPS2  = 4'd2;
  localparam logic [3:0] SUM_CRAPS3  = 4'd3;
  localparam logic [3:0] SUM_CRAPS12 = 4'd12;
  localparam logic [2:0] DIE_MIN     = 3'd1;
  localparam logic [2:0] DIE_MAX     = 3'd6;

  function automatic logic die_ok(input logic [2:0] d);
    return (d >= DIE_MIN) && (d <= DIE_MAX);
  endfunction

endpackage

// File: rtl/craps_referee_btn_edge.sv
// Registered rising-edge detector for a synchronous button level.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  logic btn_q;
  logic btn_d;

  always_comb begin
    btn_d = btn;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) btn_q <= 1'b0;
    else      btn_q <= btn_d;
  end

  assign rise = btn & ~btn_q;

endmodule

// File: rtl/craps_referee.sv
// Craps referee: samples dice on roll requests, tracks come-out/point phase and tallies.
//  state   | meaning
//  S_READY | come-out roll pending, no point
//  S_POINT | point established, rolling for point or seven
//  S_WIN   | game won, waiting for new_game
//  S_LOSE  | game lost, waiting for new_game
module craps_referee
  import craps_pkg::*;
#(
  parameter int ROLL_CNT_W = 4,
  parameter int STAT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  roll,
  input  logic                  new_game,
  input  logic [2:0]            dice1_in,
  input  logic [2:0]            dice2_in,
  output logic [3:0]            sum,
  output logic [3:0]            point,
  output logic [1:0]            state,
  output logic                  roll_done,
  output logic                  dice_err,
  output logic                  win,
  output logic                  lose,
  output logic [ROLL_CNT_W-1:0] roll_cnt,
  output logic [STAT_W-1:0]     win_cnt,
  output logic [STAT_W-1:0]     loss_cnt
);

  logic roll_rise;
  logic ng_rise;

  btn_edge u_roll_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (roll),
    .rise (roll_rise)
  );

  btn_edge u_ng_edge (
    .clk  (clk),
    .rst  (rst),
    .btn  (new_game),
    .rise (ng_rise)
  );

  state_e                state_q, state_d;
  logic [3:0]            sum_q, sum_d;
  logic [3:0]            point_q, point_d;
  logic                  roll_done_q, roll_done_d;
  logic                  dice_err_q, dice_err_d;
  logic [ROLL_CNT_W-1:0] roll_cnt_q, roll_cnt_d;
  logic [STAT_W-1:0]     win_cnt_q, win_cnt_d;
  logic [STAT_W-1:0]     loss_cnt_q, loss_cnt_d;

  logic [3:0] roll_sum;
  logic       dice_legal;
  logic       in_play;

  assign roll_sum   = {1'b0, dice1_in} + {1'b0, dice2_in};
  assign dice_legal = die_ok(dice1_in) && die_ok(dice2_in);
  assign in_play    = (state_q == S_READY) || (state_q == S_POINT);

  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    point_d     = point_q;
    roll_done_d = 1'b0;
    dice_err_d  = 1'b0;
    roll_cnt_d  = roll_cnt_q;
    win_cnt_d   = win_cnt_q;
    loss_cnt_d  = loss_cnt_q;

    // new_game takes priority; a simultaneous roll is dropped entirely
    if (ng_rise) begin
      state_d    = S_READY;
      point_d    = 4'd0;
      sum_d      = 4'd0;
      roll_cnt_d = '0;
    end else if (roll_rise && in_play) begin
      if (!dice_legal) begin
        dice_err_d = 1'b1;
      end else begin
        sum_d       = roll_sum;
        roll_done_d = 1'b1;
        if (roll_cnt_q != '1) roll_cnt_d = roll_cnt_q + ROLL_CNT_W'(1);

        if (state_q == S_READY) begin
          if (roll_sum == SUM_SEVEN || roll_sum == SUM_ELEVEN) begin
            state_d = S_WIN;
          end else if (roll_sum == SUM_CRAPS2 || roll_sum == SUM_CRAPS3 ||
                       roll_sum == SUM_CRAPS12) begin
            state_d = S_LOSE;
          end else begin
            point_d = roll_sum;
            state_d = S_POINT;
          end
        end else begin
          if (roll_sum == point_q)        state_d = S_WIN;
          else if (roll_sum == SUM_SEVEN) state_d = S_LOSE;
        end

        // tallies bump only on the transition out of play, so once per game
        if (state_d == S_WIN && win_cnt_q != '1)
          win_cnt_d = win_cnt_q + STAT_W'(1);
        if (state_d == S_LOSE && loss_cnt_q != '1)
          loss_cnt_d = loss_cnt_q + STAT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_READY;
      sum_q       <= 4'd0;
      point_q     <= 4'd0;
      roll_done_q <= 1'b0;
      dice_err_q  <= 1'b0;
      roll_cnt_q  <= '0;
      win_cnt_q   <= '0;
      loss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      point_q     <= point_d;
      roll_done_q <= roll_done_d;
      dice_err_q  <= dice_err_d;
      roll_cnt_q  <= roll_cnt_d;
      win_cnt_q   <= win_cnt_d;
      loss_cnt_q  <= loss_cnt_d;
    end
  end

  assign sum       = sum_q;
  assign point     = point_q;
  assign state     = state_q;
  assign roll_done = roll_done_q;
  assign dice_err  = dice_err_q;
  assign win       = (state_q == S_WIN);
  assign lose      = (state_q == S_LOSE);
  assign roll_cnt  = roll_cnt_q;
  assign win_cnt   = win_cnt_q;
  assign loss_cnt  = loss_cnt_q;

endmodule
